// File: rtl/fetch_decode_stage_pkg.sv
// fetch_decode_stage_pkg
//   Core-wide definitions shared by the fetch/decode slice: instruction field
//   bit positions, reset PC default, NOP encoding, the fetch state enum and a
//   word-alignment helper.
//   Optional feature macro: FETCH_DELAY_SLOT_EN (adds S_DS_PEND).
package fetch_decode_stage_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1
`ifdef FETCH_DELAY_SLOT_EN
    ,S_DS_PEND = 2'd2
`endif
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_skid_buffer.sv
// fetch_skid_buffer
//   Single-entry {instr, pc} holding register. Captures a fetched word that
//   could not enter IF/ID because the hazard unit was stalling.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     load                capture {load_instr, load_pc}
//     unload              entry consumed by IF/ID, buffer empties
//     clear               discard the entry (redirect)
//     load_instr/load_pc  data to capture
//     full                buffer holds an entry
//     instr/pc            held entry
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Instruction fetch unit plus IF/ID register. Owns the PC, fetches words
//   over a req/ack handshake, holds the fetched word in IF/ID and slices it
//   into decode fields.
//   Optional feature macro: FETCH_DELAY_SLOT_EN (MIPS branch delay slot).
//   Ports:
//     clk, rst_n                clock, synchronous active-low reset
//     imem_addr/req             fetch address (= pc) and request
//     imem_rdata/ack            returned word and completion strobe
//     stall                     hazard unit holds IF/ID
//     redirect/redirect_pc      taken branch/jump and its target
//     id_valid/pc/pc_plus4      IF/ID status and address
//     id_instr + field slices   raw instruction and decode fields
//
//   state     | meaning
//   S_FETCH   | request outstanding at pc
//   S_HOLD    | fetched word parked in skid buffer, waiting for stall to drop
//   S_DS_PEND | redirect seen, fetching the delay slot before jumping
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] FLUSH_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_clear;
  logic         skid_full;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic         fetching;
  logic         take_ack;

`ifdef FETCH_DELAY_SLOT_EN
  logic [31:0]  ds_target;
`endif

  assign fetching  = (state != S_HOLD);
  assign imem_req  = rst_n && fetching;
  assign imem_addr = pc;

  // An acked word is kept unless a flush-style redirect drops it.
`ifdef FETCH_DELAY_SLOT_EN
  assign take_ack   = fetching && imem_ack;
  assign skid_clear = 1'b0;
`else
  assign take_ack   = fetching && imem_ack && !redirect;
  assign skid_clear = redirect;
`endif
  assign skid_load   = rst_n && take_ack && stall;
  assign skid_unload = rst_n && (state == S_HOLD) && !stall;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= FLUSH_INSTR;
      id_pc    <= '0;
`ifdef FETCH_DELAY_SLOT_EN
      ds_target <= '0;
`endif
    end
`ifndef FETCH_DELAY_SLOT_EN
    else if (redirect) begin
      pc       <= word_align(redirect_pc);
      id_valid <= 1'b0;
      id_instr <= FLUSH_INSTR;
      state    <= S_FETCH;
    end
`endif
    else begin
      case (state)
        S_HOLD: begin
          if (!stall && skid_full) begin
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
            id_valid <= 1'b1;
            state    <= S_FETCH;
          end
`ifdef FETCH_DELAY_SLOT_EN
          // The parked word already is the delay slot; just retarget pc.
          if (redirect) pc <= word_align(redirect_pc);
`endif
        end
        default: begin
          if (imem_ack) begin
            if (!stall) begin
              id_instr <= imem_rdata;
              id_pc    <= pc;
              id_valid <= 1'b1;
            end
            state <= stall ? S_HOLD : S_FETCH;
`ifdef FETCH_DELAY_SLOT_EN
            if (redirect)               pc <= word_align(redirect_pc);
            else if (state == S_DS_PEND) pc <= ds_target;
            else                         pc <= pc + 32'd4;
`else
            pc <= pc + 32'd4;
`endif
          end else begin
            if (!stall) begin
              id_valid <= 1'b0;
              id_instr <= FLUSH_INSTR;
            end
`ifdef FETCH_DELAY_SLOT_EN
            if (redirect) begin
              ds_target <= word_align(redirect_pc);
              state     <= S_DS_PEND;
            end
`endif
          end
        end
      endcase
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;
  assign id_opcode   = id_instr[OPC_HI:OPC_LO];
  assign id_rs       = id_instr[RS_HI:RS_LO];
  assign id_rt       = id_instr[RT_HI:RT_LO];
  assign id_rd       = id_instr[RD_HI:RD_LO];
  assign id_shamt    = id_instr[SH_HI:SH_LO];
  assign id_funct    = id_instr[FN_HI:FN_LO];
  assign id_imm16    = id_instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage
//   Directed bench for fetch_decode_stage in its default build
//   (FETCH_DELAY_SLOT_EN undefined). Inputs change and outputs are sampled
//   1 time unit after each rising edge.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;

  int checks = 0;
  int errors = 0;

  fetch_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .id_imm16    (id_imm16)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rdata  = 32'h0;
    imem_ack    = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    step();
    step();
    check("rst_req",      {31'd0, imem_req}, 32'd0);
    check("rst_valid",    {31'd0, id_valid}, 32'd0);
    check("rst_instr",    id_instr, 32'h0);
    check("rst_pc_id",    id_pc, 32'h0);
    check("rst_addr",     imem_addr, 32'h0);

    rst_n = 1'b1;
    #1;
    check("req_after_rst", {31'd0, imem_req}, 32'd1);

    // Back-to-back fetches
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    check("pre_ack_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("f0_valid",  {31'd0, id_valid}, 32'd1);
    check("f0_imm",    {16'd0, id_imm16}, 32'h0005);
    check("f0_rt",     {27'd0, id_rt}, 32'd8);
    check("f0_opc",    {26'd0, id_opcode}, 32'd8);
    check("f0_pc4",    id_pc_plus4, 32'd4);
    check("f0_addr",   imem_addr, 32'd4);
    imem_rdata = 32'h2009_FFFF;
    step();
    check("f1_imm",    {16'd0, id_imm16}, 32'hFFFF);
    check("f1_rt",     {27'd0, id_rt}, 32'd9);
    check("f1_pc4",    id_pc_plus4, 32'd8);
    check("f1_addr",   imem_addr, 32'd8);

    // Ack at pc=8 under stall, stall held 3 cycles
    imem_rdata = 32'h0109_5020;
    stall      = 1'b1;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_req",   {31'd0, imem_req}, 32'd0);
      check("hold_idpc",  id_pc, 32'd4);
      check("hold_instr", id_instr, 32'h2009_FFFF);
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    check("unld_idpc",  id_pc, 32'd8);
    check("unld_valid", {31'd0, id_valid}, 32'd1);
    check("unld_rd",    {27'd0, id_rd}, 32'd10);
    check("unld_rs",    {27'd0, id_rs}, 32'd8);
    check("unld_funct", {26'd0, id_funct}, 32'h20);
    check("unld_req",   {31'd0, imem_req}, 32'd1);
    check("unld_addr",  imem_addr, 32'd12);

    imem_ack   = 1'b1;
    imem_rdata = 32'h0009_4080;
    step();
    check("sll_idpc",  id_pc, 32'd12);
    check("sll_shamt", {27'd0, id_shamt}, 32'd2);
    check("sll_rd",    {27'd0, id_rd}, 32'd8);
    check("sll_addr",  imem_addr, 32'd16);

    // Redirect with ack at pc=16: data dropped
    imem_rdata  = 32'hDEAD_BEEF;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_instr", id_instr, 32'h0);
    check("redir_addr",  imem_addr, 32'h100);

    imem_rdata = 32'h8C88_0004;
    step();
    check("tgt_valid", {31'd0, id_valid}, 32'd1);
    check("tgt_idpc",  id_pc, 32'h100);
    check("tgt_opc",   {26'd0, id_opcode}, 32'h23);
    check("tgt_addr",  imem_addr, 32'h104);

    // Four cycles without ack: bubbles, address held
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bub_valid", {31'd0, id_valid}, 32'd0);
      check("bub_instr", id_instr, 32'h0);
      check("bub_addr",  imem_addr, 32'h104);
    end

    // PC wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",  id_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    imem_rdata = 32'h2008_0005;
    step();
    check("pre_rst_addr",  imem_addr, 32'd4);
    check("pre_rst_valid", {31'd0, id_valid}, 32'd1);

    // Reset with a pending request and an ack in the reset cycle
    rst_n      = 1'b0;
    imem_rdata = 32'hAAAA_AAAA;
    #1;
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    step();
    check("mrst_addr",  imem_addr, 32'h0);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_instr", id_instr, 32'h0);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("mrst_req1", {31'd0, imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction fetch unit plus IF/ID pipeline register for the 32-bit MIPS-style core.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction in IF/ID and splits it into decode fields.
- id_imm16 drives the downstream 16-to-32 sign extender directly.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FLUSH_INSTR, 32'h0000_0000, id_instr value written on flush/bubble (NOP).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  32  fetch address, equals pc, low 2 bits always 0.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word, valid only in a cycle with imem_ack.
- imem_ack  in  1  fetch completes this cycle; legal only while imem_req=1.
- stall  in  1  hazard unit holds IF/ID.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0).
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  32  address of id_instr.
- id_pc_plus4  out  32  id_pc+4, for link/branch base.
- id_instr  out  32  raw instruction.
- id_opcode  out  6  id_instr[31:26].
- id_rs  out  5  [25:21].
- id_rt  out  5  [20:16].
- id_rd  out  5  [15:11].
- id_shamt  out  5  [10:6].
- id_funct  out  6  [5:0].
- id_imm16  out  16  [15:0], to sign extender.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, state=S_FETCH.
  - id_valid=0, id_instr=FLUSH_INSTR, id_pc=0, skid buffer empty.
  - imem_req=0 while rst_n=0.
- States: S_FETCH, S_HOLD, S_DS_PEND (S_DS_PEND exists only with the optional feature).
- imem_req=1 in S_FETCH and S_DS_PEND, 0 in S_HOLD.
- imem_addr=pc, stable until ack or redirect. Memory samples addr only in the ack cycle, so abandoning a request is legal.
- S_FETCH, ack=1, stall=0:
  - IF/ID <= {rdata, pc}, id_valid<=1, pc<=pc+4.
  - Fetch-to-ID latency is 1 cycle.
  - Back-to-back acks give 1 instruction per cycle.
- S_FETCH, ack=1, stall=1:
  - IF/ID unchanged; {rdata, pc} goes to the skid buffer.
  - pc<=pc+4, goto S_HOLD.
- S_FETCH, ack=0: if stall=0, id_valid<=0 and id_instr<=FLUSH_INSTR (bubble); if stall=1, IF/ID holds.
- S_HOLD:
  - While stall=1, everything holds.
  - When stall=0, buffer moves to IF/ID with id_valid<=1, buffer empties, goto S_FETCH. No fetch is issued that cycle.
- Redirect has priority over stall and ack in every state:
  - pc<=redirect_pc&~3.
  - IF/ID flushed (id_valid<=0, id_instr<=FLUSH_INSTR).
  - Skid buffer discarded; any ack data that cycle is dropped.
  - Goto S_FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- Field outputs are combinational slices of the id_instr register.
- Reset mid-operation (any state, outstanding req) returns to reset values next edge; an ack during the reset cycle is ignored.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - redirect with ack in the same cycle: the acked word (the delay slot) is accepted normally (IF/ID or skid buffer per stall) and pc<=redirect_pc. No flush.
  - redirect without ack: target is latched, goto S_DS_PEND, IF/ID not flushed. On the next ack at pc, the delay-slot word is accepted, pc<=latched target, goto S_FETCH.
  - A redirect arriving in S_DS_PEND overrides the latched target.
- Undefined: S_DS_PEND is absent and redirect behaves as flush-and-jump as above.

Decomposition:
- Shared package (core-wide):
  - opcode/field bit-position constants (OPC_HI=31, RS_LO=21, ...).
  - RESET_PC default.
  - NOP encoding.
  - fetch state enum typedef.
- One natural sub-module: fetch_skid_buffer, a single-entry {instr, pc} holding register with load/unload/clear.

Test Plan:
- Reset then ack every cycle with rdata=32'h2008_0005 at 0, 32'h2009_FFFF at 4: imem_addr 0,4,8; id_valid rises 1 cycle after first ack; id_imm16=16'h0005 then 16'hFFFF; id_rt=8 then 9; id_pc_plus4=4 then 8.
- Ack at pc=8 with stall=1 for 3 cycles: imem_req=0 during S_HOLD, IF/ID unchanged; stall drop → id_pc=8 one cycle later; next imem_addr=12.
- Redirect to 32'h0000_0103 same cycle as ack at pc=16: ack data dropped, id_valid=0 next cycle, next imem_addr=32'h100.
- FETCH_DELAY_SLOT_EN, redirect to 32'h200 with no ack at pc=20: S_DS_PEND; ack at 20 → id_pc=20 valid, next imem_addr=32'h200.
- No ack for 4 cycles with stall=0: id_valid=0, id_instr=FLUSH_INSTR, imem_addr held.
- pc=32'hFFFF_FFFC acked → next imem_addr=0; rst_n=0 during pending req → imem_req=0, pc=RESET_PC, id_valid=0.
